masku_operand_sequencer: RTL



---
 rtl/masku_operand_sequencer_pkg.sv | 40 ++++
 rtl/masku_operand_sequencer_if.sv | 33 +++
 rtl/masku_operand_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/masku_operand_sequencer_pkg.sv
// rtl/masku_operand_sequencer_pkg.sv - mask-unit types, operand slot map and required-slot helper
package ara_pkg;

    localparam int unsigned NrMaskFUnits = 2;
    localparam int unsigned NrMaskSlots  = NrMaskFUnits + 2;

    // Per-lane operand slot layout: mask, old destination, then one a-slot per source FU.
    localparam int unsigned SlotM = 0;
    localparam int unsigned SlotB = 1;
    localparam int unsigned SlotA = 2;

    typedef enum logic {
        MaskFuAlu,
        MaskFuFpu
    } masku_fu_e;

    typedef enum logic [1:0] {
        SeqIdle,
        SeqRun,
        SeqDone
    } masku_seq_state_e;

    function automatic logic [NrMaskSlots-1:0] masku_required_slots(
        input masku_fu_e fu,
        input logic      vm,
        input logic      use_vd
    );
        logic [NrMaskSlots-1:0] slots;
        slots        = '0;
        slots[SlotM] = ~vm;
        slots[SlotB] = use_vd;
        case (fu)
            MaskFuAlu: slots[SlotA]     = 1'b1;
            MaskFuFpu: slots[SlotA + 1] = 1'b1;
            default:   slots            = slots;
        endcase
        return slots;
    endfunction

endpackage

// File: rtl/masku_operand_sequencer_if.sv
// rtl/masku_operand_sequencer_if.sv - instruction handshake bundle into the operand sequencer
interface masku_operand_sequencer_if
    import ara_pkg::*;
#(
    parameter int unsigned BeatWidth = 16
);

    logic                 instr_valid_i;
    logic                 instr_ready_o;
    masku_fu_e            instr_fu_i;
    logic                 instr_vm_i;
    logic                 instr_use_vd_i;
    logic [BeatWidth-1:0] instr_beats_i;

    modport master (
        output instr_valid_i,
        output instr_fu_i,
        output instr_vm_i,
        output instr_use_vd_i,
        output instr_beats_i,
        input  instr_ready_o
    );

    modport slave (
        input  instr_valid_i,
        input  instr_fu_i,
        input  instr_vm_i,
        input  instr_use_vd_i,
        input  instr_beats_i,
        output instr_ready_o
    );

endinterface

// File: rtl/masku_operand_sequencer.sv
// rtl/masku_operand_sequencer.sv - gathers per-lane mask operands into lockstep beats for one instruction
module masku_operand_sequencer
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes   = 0,
    parameter int unsigned BeatWidth = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    masku_operand_sequencer_if.slave                instr,
    input  logic [NrLanes-1:0][NrMaskSlots-1:0]     op_valid_i,
    output logic [NrLanes-1:0][NrMaskSlots-1:0]     op_ready_o,
    output masku_fu_e                               fu_sel_o,
    output logic                                    beat_valid_o,
    input  logic                                    beat_ready_i,
    output logic                                    last_beat_o,
    output logic                                    done_o,
    input  logic                                    flush_i
);

    masku_seq_state_e     state_q, state_d;
    logic [BeatWidth-1:0] beats_q, beats_d;
    masku_fu_e            fu_q, fu_d;
    logic                 vm_q, vm_d;
    logic                 use_vd_q, use_vd_d;

    logic [NrMaskSlots-1:0] req_slots;
    logic                   all_lanes_valid;
    logic                   fire;

    assign req_slots = masku_required_slots(fu_q, vm_q, use_vd_q);
    assign fu_sel_o  = fu_q;

    // A lane is ready when every required slot is valid; slots not required are don't-care.
    always_comb begin
        all_lanes_valid = 1'b1;
        for (int unsigned l = 0; l < NrLanes; l++) begin
            if ((op_valid_i[l] & req_slots) != req_slots) begin
                all_lanes_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SeqIdle;
            beats_q  <= '0;
            fu_q     <= MaskFuAlu;
            vm_q     <= 1'b0;
            use_vd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beats_q  <= beats_d;
            fu_q     <= fu_d;
            vm_q     <= vm_d;
            use_vd_q <= use_vd_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        beats_d             = beats_q;
        fu_d                = fu_q;
        vm_d                = vm_q;
        use_vd_d            = use_vd_q;
        instr.instr_ready_o = 1'b0;
        beat_valid_o        = 1'b0;
        last_beat_o         = 1'b0;
        done_o              = 1'b0;
        fire                = 1'b0;

        unique case (state_q)
            SeqIdle: begin
                instr.instr_ready_o = 1'b1;
                if (instr.instr_valid_i) begin
                    fu_d     = instr.instr_fu_i;
                    vm_d     = instr.instr_vm_i;
                    use_vd_d = instr.instr_use_vd_i;
                    beats_d  = instr.instr_beats_i;
                    state_d  = (instr.instr_beats_i == '0) ? SeqDone : SeqRun;
                end
            end
            SeqRun: begin
                last_beat_o  = (beats_q == BeatWidth'(1));
                // Flush withdraws the beat so downstream never sees a handshake that consumes nothing.
                beat_valid_o = all_lanes_valid && !flush_i;
                fire         = beat_valid_o && beat_ready_i;
                if (flush_i) begin
                    beats_d = '0;
                    state_d = SeqDone;
                end else if (fire) begin
                    beats_d = beats_q - BeatWidth'(1);
                    if (beats_q == BeatWidth'(1)) begin
                        state_d = SeqDone;
                    end
                end
            end
            SeqDone: begin
                done_o  = 1'b1;
                state_d = SeqIdle;
            end
            default: begin
                state_d = SeqIdle;
            end
        endcase
    end

    always_comb begin
        op_ready_o = '0;
        if (fire) begin
            for (int unsigned l = 0; l < NrLanes; l++) begin
                op_ready_o[l] = req_slots;
            end
        end
    end

endmodule
